axi4_lite_slave_regs: RTL

AXI4-Lite slave register bank that terminates the write traffic produced by the team's LUT-driven AXI4-Lite master and also serves reads of the same registers. It decodes word addresses into `NUM_REGS` registers, applies byte strobes, returns OKAY/SLVERR responses, and exposes register contents and per-register write pulses to downstream fabric logic. AW and W channels are accepted independently, in either order; at most one write and one read are outstanding at a time.

---
 rtl/axi4_lite_slave_regs.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_slave_regs.sv
// rtl/axi4_lite_slave_regs.sv - AXI4-Lite slave register bank with strobes, SLVERR decode and write pulses
module axi4_lite_slave_regs #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int NUM_REGS      = 16
) (
   input  logic                           aclk,
   input  logic                           aresetn,
   input  logic [ADDRESS_WIDTH-1:0]       s_axi_awaddr,
   input  logic                           s_axi_awvalid,
   output logic                           s_axi_awready,
   input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
   input  logic                           s_axi_wvalid,
   output logic                           s_axi_wready,
   output logic [1:0]                     s_axi_bresp,
   output logic                           s_axi_bvalid,
   input  logic                           s_axi_bready,
   input  logic [ADDRESS_WIDTH-1:0]       s_axi_araddr,
   input  logic                           s_axi_arvalid,
   output logic                           s_axi_arready,
   output logic [DATA_WIDTH-1:0]          s_axi_rdata,
   output logic [1:0]                     s_axi_rresp,
   output logic                           s_axi_rvalid,
   input  logic                           s_axi_rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   output logic [NUM_REGS-1:0]            write_pulse,
   output logic [7:0]                     error_count
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int LSB    = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(NUM_REGS);
   localparam logic [ADDRESS_WIDTH:0] LIMIT = (ADDRESS_WIDTH+1)'(NUM_REGS * STRB_W);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {WrIdle, WrCommit, WrResp} wr_state_e;
   typedef enum logic {RdIdle, RdResp} rd_state_e;

   wr_state_e               wr_state_q, wr_state_d;
   rd_state_e               rd_state_q, rd_state_d;
   logic                    aw_have_q, aw_have_d, w_have_q, w_have_d;
   logic [ADDRESS_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]       wstrb_q, wstrb_d;
   logic                    awready_q, awready_d, wready_q, wready_d;
   logic                    bvalid_q, bvalid_d;
   logic [1:0]              bresp_q, bresp_d;
   logic                    arready_q, arready_d, rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;
   logic [NUM_REGS-1:0]     write_pulse_q, write_pulse_d;
   logic [7:0]              error_count_q, error_count_d;
   logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

   logic                    aw_hs, w_hs, ar_hs, wr_commit;
   logic                    wr_in_range, rd_in_range, wr_err, rd_err;
   logic [IDX_W-1:0]        wr_idx, rd_idx;
   logic [8:0]              err_sum;

   assign aw_hs       = s_axi_awvalid & awready_q;
   assign w_hs        = s_axi_wvalid & wready_q;
   assign ar_hs       = s_axi_arvalid & arready_q;
   assign wr_in_range = {1'b0, awaddr_q} < LIMIT;
   assign rd_in_range = {1'b0, s_axi_araddr} < LIMIT;
   assign wr_idx      = awaddr_q[LSB +: IDX_W];
   assign rd_idx      = s_axi_araddr[LSB +: IDX_W];

   // Write FSM: gather AW and W in any order, commit for one cycle, then hold B until accepted
   always_comb begin
      wr_state_d = wr_state_q;
      aw_have_d  = aw_have_q;
      w_have_d   = w_have_q;
      awaddr_d   = awaddr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      wr_commit  = 1'b0;
      case (wr_state_q)
         WrIdle: begin
            if (aw_hs) begin
               aw_have_d = 1'b1;
               awaddr_d  = s_axi_awaddr;
            end
            if (w_hs) begin
               w_have_d = 1'b1;
               wdata_d  = s_axi_wdata;
               wstrb_d  = s_axi_wstrb;
            end
            if (aw_have_d && w_have_d) wr_state_d = WrCommit;
         end
         WrCommit: begin
            wr_commit  = 1'b1;
            bvalid_d   = 1'b1;
            bresp_d    = wr_in_range ? RESP_OKAY : RESP_SLVERR;
            wr_state_d = WrResp;
         end
         WrResp: begin
            if (s_axi_bready) begin
               bvalid_d   = 1'b0;
               aw_have_d  = 1'b0;
               w_have_d   = 1'b0;
               wr_state_d = WrIdle;
            end
         end
         default: wr_state_d = WrIdle;
      endcase
      awready_d = (wr_state_d == WrIdle) && !aw_have_d;
      wready_d  = (wr_state_d == WrIdle) && !w_have_d;
   end

   // Read FSM: sample the register bank at the AR handshake, hold R until accepted
   always_comb begin
      rd_state_d = rd_state_q;
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      case (rd_state_q)
         RdIdle: begin
            if (ar_hs) begin
               rdata_d    = rd_in_range ? regs_q[rd_idx] : '0;
               rresp_d    = rd_in_range ? RESP_OKAY : RESP_SLVERR;
               rvalid_d   = 1'b1;
               rd_state_d = RdResp;
            end
         end
         RdResp: begin
            if (s_axi_rready) begin
               rvalid_d   = 1'b0;
               rd_state_d = RdIdle;
            end
         end
         default: rd_state_d = RdIdle;
      endcase
      arready_d = (rd_state_d == RdIdle);
   end

   // Write pulse and saturating error counter; simultaneous read and write errors add two
   always_comb begin
      write_pulse_d = '0;
      if (wr_commit && wr_in_range) write_pulse_d[wr_idx] = 1'b1;
      wr_err        = wr_commit & !wr_in_range;
      rd_err        = ar_hs & !rd_in_range;
      err_sum       = {1'b0, error_count_q} + 9'(wr_err) + 9'(rd_err);
      error_count_d = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
   end

   // Control and response state registers
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_state_q    <= WrIdle;
         rd_state_q    <= RdIdle;
         aw_have_q     <= 1'b0;
         w_have_q      <= 1'b0;
         awaddr_q      <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         awready_q     <= 1'b0;
         wready_q      <= 1'b0;
         bvalid_q      <= 1'b0;
         bresp_q       <= 2'b00;
         arready_q     <= 1'b0;
         rvalid_q      <= 1'b0;
         rdata_q       <= '0;
         rresp_q       <= 2'b00;
         write_pulse_q <= '0;
         error_count_q <= '0;
      end else begin
         wr_state_q    <= wr_state_d;
         rd_state_q    <= rd_state_d;
         aw_have_q     <= aw_have_d;
         w_have_q      <= w_have_d;
         awaddr_q      <= awaddr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         awready_q     <= awready_d;
         wready_q      <= wready_d;
         bvalid_q      <= bvalid_d;
         bresp_q       <= bresp_d;
         arready_q     <= arready_d;
         rvalid_q      <= rvalid_d;
         rdata_q       <= rdata_d;
         rresp_q       <= rresp_d;
         write_pulse_q <= write_pulse_d;
         error_count_q <= error_count_d;
      end
   end

   // Register bank: byte-strobed update on an in-range commit
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (wr_commit && wr_in_range) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb_q[b]) regs_q[wr_idx][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
         assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
      end
   endgenerate

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign write_pulse   = write_pulse_q;
   assign error_count   = error_count_q;

endmodule
